// File: rtl/mem_access_pkg.sv
// mem_access_pkg: memory-op encodings, stage constants and op-decoding helpers
package mem_access_pkg;
  localparam logic [3:0] OpNone = 4'd0, OpLb = 4'd1, OpLbu = 4'd2, OpLh = 4'd3, OpLhu = 4'd4,
                         OpLw = 4'd5, OpSb = 4'd6, OpSh = 4'd7, OpSw = 4'd8, OpLd = 4'd9, OpSd = 4'd10;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam int NOPRegAddr = 0;
  localparam logic [63:0] ZeroWord = '0;
  localparam logic [1:0] ExcpNone = 2'b00, ExcpMisalign = 2'b01, ExcpTimeout = 2'b10;
  typedef enum logic {IDLE, BUSY} state_e;
  function automatic logic is_load(input logic [3:0] op, input int dw);
    return (op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw}) || (dw == 64 && op == OpLd);
  endfunction
  function automatic logic is_store(input logic [3:0] op, input int dw);
    return (op inside {OpSb, OpSh, OpSw}) || (dw == 64 && op == OpSd);
  endfunction
  function automatic logic op_signed(input logic [3:0] op);
    return op inside {OpLb, OpLh, OpLw};
  endfunction
  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input logic [3:0] op);
    return (op inside {OpLb, OpLbu, OpSb}) ? 2'd0 : (op inside {OpLh, OpLhu, OpSh}) ? 2'd1 :
           (op inside {OpLw, OpSw}) ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed lanes of a read word and sign/zero-extends them
module load_align import mem_access_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]                  op_i,
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  logic [DATA_W-1:0]           rdata_i,
  output logic [DATA_W-1:0]           data_o
);
  logic [DATA_W-1:0] lane, top;
  int pad;
  always_comb begin
    pad = DATA_W - (8 << op_size(op_i));
    lane = rdata_i >> {off_i, 3'b000};
    top = lane << pad;
    data_o = op_signed(op_i) ? DATA_W'($signed(top) >>> pad) : top >> pad;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: load/store stage; forwards ALU results and runs one bus transaction at a time
module mem_access import mem_access_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [REG_AW-1:0]   wd_i,
  input  logic                wreg_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [3:0]          mem_op_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_sdata_i,
  input  logic                flush_i,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                stall_req_o,
  output logic [1:0]          excp_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d, wd_q, wd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0] sel_q, sel_d, sel_in;
  logic [DATA_W-1:0] sdata_q, sdata_d, rep_in, wdata_q, wdata_d, ld_data;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fl_q, fl_d, wreg_q, wreg_d, aligned, busy;
  logic [1:0] excp_q, excp_d, sz;
  logic [OW-1:0] off;
  load_align #(.DATA_W(DATA_W)) u_load_align (
    .op_i(op_q), .off_i(addr_q[OW-1:0]), .rdata_i(mem_rdata_i), .data_o(ld_data)
  );
  // byte enables and store data replicated across every lane the access size repeats into
  always_comb begin
    off = mem_addr_i[OW-1:0];
    sz = op_size(mem_op_i);
    aligned = (off & OW'((1 << sz) - 1)) == '0;
    sel_in = NB'(((1 << (1 << sz)) - 1) << off);
    for (int i = 0; i < NB; i++) rep_in[8*i +: 8] = mem_sdata_i[8*(i & ((1 << sz) - 1)) +: 8];
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rd_d = rd_q;
    addr_d = addr_q;
    sel_d = sel_q;
    sdata_d = sdata_q;
    cnt_d = cnt_q;
    fl_d = fl_q;
    wd_d = REG_AW'(NOPRegAddr);
    wreg_d = WriteDisable;
    wdata_d = DATA_W'(ZeroWord);
    excp_d = ExcpNone;
    if (state_q == IDLE) begin
      if (valid_i && !flush_i) begin
        if (!is_load(mem_op_i, DATA_W) && !is_store(mem_op_i, DATA_W)) begin
          wd_d = wd_i;
          wreg_d = wreg_i;
          wdata_d = wdata_i;
        end else if (!aligned) begin
          excp_d = ExcpMisalign;
        end else begin
          state_d = BUSY;
          op_d = mem_op_i;
          rd_d = wd_i;
          addr_d = mem_addr_i;
          sel_d = sel_in;
          sdata_d = rep_in;
          cnt_d = '0;
          fl_d = 1'b0;
        end
      end
    end else begin
      fl_d = fl_q | flush_i;
      cnt_d = cnt_q + CW'(1);
      if (mem_ack_i) begin
        state_d = IDLE;
        if (is_load(op_q, DATA_W) && !fl_d) begin
          wd_d = rd_q;
          wreg_d = 1'b1;
          wdata_d = ld_data;
        end
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        excp_d = ExcpTimeout;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IDLE;
      op_q <= OpNone;
      rd_q <= '0;
      addr_q <= '0;
      sel_q <= '0;
      sdata_q <= '0;
      cnt_q <= '0;
      fl_q <= 1'b0;
      wd_q <= '0;
      wreg_q <= WriteDisable;
      wdata_q <= '0;
      excp_q <= ExcpNone;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      sdata_q <= sdata_d;
      cnt_q <= cnt_d;
      fl_q <= fl_d;
      wd_q <= wd_d;
      wreg_q <= wreg_d;
      wdata_q <= wdata_d;
      excp_q <= excp_d;
    end
  end
  assign busy = state_q == BUSY;
  assign stall_req_o = busy;
  assign mem_req_o = busy;
  assign mem_we_o = busy && is_store(op_q, DATA_W);
  assign mem_addr_o = busy ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
  assign mem_sel_o = busy ? sel_q : '0;
  assign mem_wdata_o = busy ? sdata_q : '0;
  assign wd_o = wd_q;
  assign wreg_o = wreg_q;
  assign wdata_o = wdata_q;
  assign excp_o = excp_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench with a byte-level memory reference model
module tb_mem_access;
  import mem_access_pkg::*;
  localparam int TO = 4;
  logic clk = 1'b0, rst;
  logic valid_i, wreg_i, flush_i, wreg_o, stall_req_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [4:0] wd_i, wd_o;
  logic [31:0] wdata_i, mem_addr_i, mem_sdata_i, wdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_op_i, mem_sel_o;
  logic [1:0] excp_o;
  always #5 clk = ~clk;
  mem_access #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .flush_i(flush_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o), .excp_o(excp_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );
  typedef struct {logic [4:0] wd; logic [31:0] data; logic [1:0] excp; int cyc;} wb_t;
  typedef struct {logic [31:0] addr; logic we; logic [3:0] sel; logic [31:0] wdata;} bus_t;
  wb_t wb_q[$];
  bus_t bus_q[$];
  wb_t e_mon;
  bus_t cur;
  logic [7:0] mem_ref [0:65535];
  logic [7:0] mem_bus [0:65535];
  int cyc = 0, checks = 0, passed = 0, ack_delay = 0, wcnt = 0;
  bit no_ack = 0, force_ack = 0, seen = 0;
  logic [3:0] ops [9] = '{OpNone, OpLb, OpLbu, OpLh, OpLhu, OpLw, OpSb, OpSh, OpSw};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic int nbytes(input logic [3:0] op);
    return (op inside {OpLb, OpLbu, OpSb}) ? 1 : (op inside {OpLh, OpLhu, OpSh}) ? 2 :
           (op inside {OpLw, OpSw}) ? 4 : 0;
  endfunction
  function automatic logic [31:0] ld_val(input logic [3:0] op, input logic [31:0] a);
    longint v = 0;
    int n = nbytes(op);
    for (int k = 0; k < n; k++) v = v + (longint'(mem_ref[int'(a[15:0]) + k]) << (8 * k));
    if ((op inside {OpLb, OpLh, OpLw}) && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wr, input logic [31:0] alu,
                       input bit fl_now, input bit fl_busy, input int d, input bit na);
    int n, k, busy, c;
    logic [3:0] sel;
    logic [31:0] rep;
    bit ld;
    n = nbytes(op);
    ld = op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw};
    k = na ? TO : d + 1;
    ack_delay = d;
    no_ack = na;
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = a; mem_sdata_i = sd;
    wd_i = wd; wreg_i = wr; wdata_i = alu; flush_i = fl_now;
    c = cyc;
    if (fl_now) ;
    else if (n == 0) begin
      if (wr) wb_q.push_back('{wd, alu, 2'b00, c + 1});
    end else if (a % n != 0) wb_q.push_back('{5'd0, 32'd0, 2'b01, c + 1});
    else begin
      for (int i = 0; i < 4; i++) begin
        sel[i] = (i >= a % 4) && (i < a % 4 + n);
        rep[8*i +: 8] = sd[8*(i % n) +: 8];
      end
      bus_q.push_back('{{a[31:2], 2'b00}, !ld, sel, rep});
      if (na) wb_q.push_back('{5'd0, 32'd0, 2'b10, c + TO + 1});
      else if (ld && !fl_busy) wb_q.push_back('{wd, ld_val(op, a), 2'b00, c + k + 1});
      if (!ld && !na) for (int j = 0; j < n; j++) mem_ref[int'(a[15:0]) + j] = sd[8*j +: 8];
    end
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    if (n != 0 && a % n == 0 && !fl_now) begin
      busy = 0;
      while (stall_req_o && busy < 20) begin
        busy++;
        valid_i = 1'($urandom_range(0, 1));
        mem_op_i = ops[$urandom_range(0, 8)];
        mem_addr_i = $urandom; wd_i = 5'($urandom); wreg_i = 1'b1; wdata_i = $urandom;
        flush_i = fl_busy && busy == 1;
        @(negedge clk);
      end
      valid_i = 1'b0; flush_i = 1'b0;
      chk("stall_cycles", 64'(busy), 64'(k));
    end else chk("no_stall", stall_req_o, 0);
  endtask
  always @(negedge clk) begin
    if (!rst && (wreg_o || excp_o != 2'b00)) begin
      if (wb_q.size() == 0) chk("unexpected_wb", {wreg_o, excp_o}, 0);
      else begin
        e_mon = wb_q.pop_front();
        chk("wb_cycle", 64'(cyc), 64'(e_mon.cyc));
        chk("wb_excp", excp_o, e_mon.excp);
        chk("wb_wreg", wreg_o, e_mon.excp == 2'b00);
        if (e_mon.excp == 2'b00) begin
          chk("wb_wd", wd_o, e_mon.wd);
          chk("wb_data", wdata_o, e_mon.data);
        end
      end
    end
  end
  initial begin
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      mem_rdata_i = $urandom;
      if (force_ack) mem_ack_i = 1'b1;
      else if (mem_req_o && !rst) begin
        if (!seen) begin
          seen = 1;
          wcnt = ack_delay;
          if (bus_q.size() == 0) chk("bus_unexpected", mem_req_o, 0);
          else cur = bus_q.pop_front();
        end
        chk("bus_addr", mem_addr_o, cur.addr);
        chk("bus_we", mem_we_o, cur.we);
        chk("bus_sel", mem_sel_o, cur.sel);
        if (cur.we) chk("bus_wdata", mem_wdata_o, cur.wdata);
        if (!no_ack && wcnt == 0) begin
          mem_ack_i = 1'b1;
          for (int i = 0; i < 4; i++) begin
            mem_rdata_i[8*i +: 8] = mem_bus[int'(mem_addr_o[15:0]) + i];
            if (mem_we_o && mem_sel_o[i]) mem_bus[int'(mem_addr_o[15:0]) + i] = mem_wdata_o[8*i +: 8];
          end
          seen = 0;
        end else wcnt--;
      end else seen = 0;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
  initial begin
    logic [3:0] op;
    bit na;
    valid_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0; mem_op_i = OpNone;
    mem_addr_i = 0; mem_sdata_i = 0; flush_i = 0; rst = 1;
    for (int i = 0; i < 65536; i++) begin
      mem_ref[i] = 8'($urandom);
      mem_bus[i] = mem_ref[i];
    end
    mem_ref[16'h1000] = 8'h00; mem_ref[16'h1001] = 8'h00; mem_ref[16'h1002] = 8'hFF; mem_ref[16'h1003] = 8'h80;
    for (int i = 16'h1000; i < 16'h1004; i++) mem_bus[i] = mem_ref[i];
    repeat (3) @(negedge clk);
    chk("rst_wd", wd_o, 0); chk("rst_wreg", wreg_o, 0); chk("rst_wdata", wdata_o, 0);
    chk("rst_excp", excp_o, 0); chk("rst_stall", stall_req_o, 0); chk("rst_req", mem_req_o, 0);
    rst = 0;
    issue(OpNone, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_1234, 0, 0, 0, 0);
    issue(OpLb, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 0, 0, 2, 0);
    issue(OpSh, 32'h2002, 32'hABCD, 5'd9, 1'b1, 32'h0, 0, 0, 0, 0);
    issue(OpLw, 32'h0006, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0, 0, 0);
    issue(OpLw, 32'h1004, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0, 0, 1);
    issue(OpLw, 32'h1008, 32'h0, 5'd5, 1'b1, 32'h0, 1, 0, 0, 0);
    issue(OpLhu, 32'h100A, 32'h0, 5'd6, 1'b1, 32'h0, 0, 1, 1, 0);
    issue(OpLh, 32'h2002, 32'h0, 5'd8, 1'b1, 32'h0, 0, 0, 3, 0);
    for (int t = 0; t < 300; t++) begin
      op = ops[$urandom_range(0, 8)];
      na = $urandom_range(0, 9) == 0;
      issue(op, 32'h1000 | 32'($urandom_range(0, 255)), $urandom, 5'($urandom), 1'($urandom),
            $urandom, $urandom_range(0, 9) == 0, !na && $urandom_range(0, 9) == 0,
            $urandom_range(0, 3), na);
    end
    no_ack = 1;
    bus_q.push_back('{32'h1010, 1'b0, 4'hF, 32'h0});
    valid_i = 1; mem_op_i = OpLw; mem_addr_i = 32'h1010; wd_i = 5'd11; wreg_i = 1; flush_i = 0;
    @(negedge clk);
    valid_i = 0;
    @(negedge clk);
    chk("busy_before_rst", stall_req_o, 1);
    rst = 1;
    @(negedge clk);
    chk("midrst_wd", wd_o, 0); chk("midrst_wreg", wreg_o, 0); chk("midrst_wdata", wdata_o, 0);
    chk("midrst_excp", excp_o, 0); chk("midrst_req", mem_req_o, 0); chk("midrst_we", mem_we_o, 0);
    chk("midrst_sel", mem_sel_o, 0); chk("midrst_stall", stall_req_o, 0);
    rst = 0;
    force_ack = 1;
    repeat (2) @(negedge clk);
    force_ack = 0;
    @(negedge clk);
    chk("late_ack_ignored", {stall_req_o, wreg_o, mem_req_o, excp_o}, 0);
    repeat (2) @(negedge clk);
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("bus_queue_empty", bus_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter DATA_W, default 32, datapath and memory data width; multiple of 8, 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter REG_AW, default 5, register-address width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles waiting for mem_ack_i before bus error; >=1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 valid_i  in  1  EX result present; accepted only in a cycle where stall_req_o is low.
REQ-008 wd_i / wreg_i / wdata_i  in  REG_AW / 1 / DATA_W  destination, write enable, ALU result.
REQ-009 mem_op_i  in  4  NONE, LB, LBU, LH, LHU, LW, SB, SH, SW (LD, SD only when DATA_W=64).
REQ-010 mem_addr_i / mem_sdata_i  in  ADDR_W / DATA_W  byte address, store data (low bytes).
REQ-011 flush_i  in  1  discard the in-flight result.
REQ-012 wd_o / wreg_o / wdata_o  out  REG_AW / 1 / DATA_W  registered writeback to WB.
REQ-013 stall_req_o  out  1  high while a memory transaction is outstanding.
REQ-014 excp_o  out  2  one-cycle pulse: 01 misaligned, 10 bus timeout, 00 none.
REQ-015 mem_req_o / mem_we_o  out  1 / 1  bus request, write strobe.
REQ-016 mem_addr_o / mem_sel_o / mem_wdata_o  out  ADDR_W / DATA_W/8 / DATA_W  word-aligned address, byte enables, lane-replicated store data.
REQ-017 mem_rdata_i / mem_ack_i  in  DATA_W / 1  read data, completion (valid for one cycle).

Function
REQ-018 FSM states IDLE, BUSY; stall_req_o = (state==BUSY), Moore.
REQ-019 IDLE, accepted non-memory op: wd_o/wreg_o/wdata_o load from inputs at the next edge (latency 1).
REQ-020 IDLE, accepted aligned memory op: capture op/address/data, go BUSY; writeback outputs drive NOP (wreg_o=0) until completion.
REQ-021 BUSY: mem_req_o=1; address, sel, we and wdata held stable until an edge where mem_ack_i=1.
REQ-022 Ack edge: go IDLE; a load writes lane-extracted, sign/zero-extended data with wreg_o=1; a store writes wreg_o=0.
REQ-023 Load latency = 1 + cycles until ack; ack in the first BUSY cycle yields 2 cycles.
REQ-024 Alignment: halfword addr[0]=0, word addr[1:0]=0, dword addr[2:0]=0; a violation emits excp_o=01 next edge, issues no bus request, and forces wreg_o=0.
REQ-025 mem_sel_o: byte = one-hot at addr lane, half = two lanes, word/dword = lanes covered; little-endian.
REQ-026 Wait counter cleared on BUSY entry; if it reaches TIMEOUT without ack: excp_o=10, wreg_o=0, go IDLE.
REQ-027 mem_ack_i outside BUSY ignored.
REQ-028 flush_i in IDLE: outputs NOP next edge and input not accepted. In BUSY: the transaction runs to ack/timeout, then the result is discarded (wreg_o=0).
REQ-029 No valid_i, or valid_i while stalled: outputs NOP next edge.

Reset
REQ-030 rst high at an edge: state IDLE, wd_o=0, wreg_o=0, wdata_o=0, excp_o=0, mem_req_o=0, mem_we_o=0, mem_sel_o=0, counter=0, including mid-transaction (a late ack is ignored).

Structure
REQ-031 The shared defines package holds the mem_op encodings, RstEnable, WriteDisable, NOPRegAddr, ZeroWord, and excp codes.
REQ-032 A sub-module load_align (combinational lane select and extend, parametrised by DATA_W) is instantiated once.

Verification
REQ-033 Non-memory op: ADD result 0x0000_1234, wd=3 -> next cycle wd_o=3, wreg_o=1, wdata_o=0x1234, stall_req_o=0.
REQ-034 LB at 0x1003, mem_rdata=0x80FF_0000, ack after 3 cycles -> wdata_o=0xFFFF_FF80, stall_req_o high for 3 cycles, sel=1000.
REQ-035 SH 0xABCD at 0x2002 -> mem_sel_o=1100, mem_wdata_o=0xABCD_ABCD, mem_we_o=1, wreg_o=0.
REQ-036 LW at 0x0006 -> excp_o=01 one cycle, mem_req_o never high, wreg_o=0.
REQ-037 LW, no ack, TIMEOUT=4 -> excp_o=10 after 4 BUSY cycles, then IDLE; rst asserted in a second BUSY -> all outputs zero next edge.
